// File: rtl/fifo_pkg.sv
// Shared types and constants for the FIFO read-side stream adapter.
// The skid buffer depth is fixed at two: one word in flight plus one already held.
package fifo_pkg;

  localparam int FIFO_DATA_WIDTH = 8;
  localparam int SKID_DEPTH      = 2;
  localparam int SKID_OCC_W      = $clog2(SKID_DEPTH + 1);

  typedef logic [FIFO_DATA_WIDTH-1:0] fifo_word_t;
  typedef logic [SKID_OCC_W-1:0]      skid_occ_t;

  // Encoded as {push, pop} so the operation can be built directly from the strobes.
  typedef enum logic [1:0] {
    SKID_IDLE = 2'b00,
    SKID_POP  = 2'b01,
    SKID_PUSH = 2'b10,
    SKID_BOTH = 2'b11
  } skid_op_e;

endpackage

// File: rtl/fifo_rd_stream_adapter_skid.sv
// Two-entry skid buffer, oldest word first; head is always entry 0.
// Flush empties the buffer and clears the stored words.
module fifo_rd_skid
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output skid_occ_t             occ,
  output logic [DATA_WIDTH-1:0] head
);

  localparam skid_occ_t SKID_FULL  = SKID_OCC_W'(SKID_DEPTH);
  localparam skid_occ_t SKID_EMPTY = '0;

  logic [DATA_WIDTH-1:0] entry_q [SKID_DEPTH];
  logic [DATA_WIDTH-1:0] entry_d [SKID_DEPTH];
  skid_occ_t             occ_q;
  skid_occ_t             occ_d;
  skid_op_e              op;

  always_comb begin
    entry_d = entry_q;
    occ_d   = occ_q;
    op      = skid_op_e'({push, pop});
    if (flush) begin
      occ_d      = SKID_EMPTY;
      entry_d[0] = '0;
      entry_d[1] = '0;
    end else begin
      unique case (op)
        SKID_PUSH: begin
          if (occ_q == SKID_EMPTY) begin
            entry_d[0] = push_data;
          end else begin
            entry_d[1] = push_data;
          end
          occ_d = occ_q + 1'b1;
        end
        SKID_POP: begin
          entry_d[0] = entry_q[1];
          occ_d      = occ_q - 1'b1;
        end
        SKID_BOTH: begin
          // Occupancy is unchanged; the arriving word lands behind whatever remains.
          if (occ_q == SKID_FULL) begin
            entry_d[0] = entry_q[1];
            entry_d[1] = push_data;
          end else begin
            entry_d[0] = push_data;
          end
        end
        default: ;
      endcase
    end
  end

  generate
    for (genvar gi = 0; gi < SKID_DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          entry_q[gi] <= '0;
        end else begin
          entry_q[gi] <= entry_d[gi];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q <= SKID_EMPTY;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occ  = occ_q;
  assign head = entry_q[0];

  // The issue rule upstream must never let a word arrive into a full buffer.
  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && !flush && occ_q == SKID_FULL));

  a_no_underflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(pop && occ_q == SKID_EMPTY));

endmodule

// File: rtl/fifo_rd_stream_adapter.sv
// Read-side master for the synchronous FIFO: issues r_en, captures the registered
// data_out a cycle later and presents it as a valid/ready stream framed into bursts.
module fifo_rd_stream_adapter
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int BURST_LEN  = 4,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  flush,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  output logic                  fifo_r_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic [CNT_W-1:0]      beats_out
);

  localparam int                 BURST_W    = $clog2(BURST_LEN);
  localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(BURST_LEN - 1);
  localparam int                 PEND_W     = SKID_OCC_W + 1;
  localparam logic [PEND_W-1:0]  PEND_LIMIT = PEND_W'(SKID_DEPTH);

  skid_occ_t             occ;
  logic [DATA_WIDTH-1:0] head;
  logic                  pop;
  logic                  capture;
  logic                  issue;
  logic [PEND_W-1:0]     pending;

  logic                  inflight_q;
  logic                  inflight_d;
  logic [BURST_W-1:0]    burst_q;
  logic [BURST_W-1:0]    burst_d;
  logic [CNT_W-1:0]      beats_q;
  logic [CNT_W-1:0]      beats_d;

  fifo_rd_skid #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .push      (capture),
    .push_data (fifo_rdata),
    .pop       (pop),
    .occ       (occ),
    .head      (head)
  );

  always_comb begin
    pop = (occ != '0) && m_ready;
    // Words held plus the one in flight, minus the one leaving this cycle; the
    // m_ready term is what keeps a full-rate stream free of bubbles.
    pending = PEND_W'(occ) + PEND_W'(inflight_q) - PEND_W'(pop);
    issue   = rst_n && en && !flush && !fifo_empty && (pending < PEND_LIMIT);
    capture = inflight_q && !flush;

    inflight_d = issue;

    burst_d = burst_q;
    if (flush) begin
      burst_d = '0;
    end else if (pop) begin
      burst_d = (burst_q == BURST_LAST) ? '0 : burst_q + 1'b1;
    end

    beats_d = beats_q + CNT_W'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q <= 1'b0;
      burst_q    <= '0;
      beats_q    <= '0;
    end else begin
      inflight_q <= inflight_d;
      burst_q    <= burst_d;
      beats_q    <= beats_d;
    end
  end

  assign fifo_r_en = issue;
  assign m_valid   = (occ != '0);
  assign m_data    = head;
  assign m_last    = m_valid && (burst_q == BURST_LAST);
  assign beats_out = beats_q;

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Directed bench: a small behavioural FIFO feeds the adapter, a monitor logs accepted
// beats, and one initial block walks through the scenarios with hand-computed values.
module tb_fifo_rd_stream_adapter;
  import fifo_pkg::*;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic             flush;
  logic             fifo_empty;
  fifo_word_t       fifo_rdata;
  logic             fifo_r_en;
  logic             m_valid;
  logic             m_ready;
  fifo_word_t       m_data;
  logic             m_last;
  logic [15:0]      beats_out;

  int n_err = 0;
  int n_chk = 0;

  fifo_word_t mem [256];
  int wr_ptr = 0;
  int rd_ptr = 0;

  fifo_word_t got      [64];
  logic       got_last [64];
  int         got_cyc  [64];
  int         n_got = 0;
  int         cyc   = 0;
  int         rd_base;

  fifo_rd_stream_adapter #(
    .DATA_WIDTH (8),
    .BURST_LEN  (4),
    .CNT_W      (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .flush      (flush),
    .fifo_empty (fifo_empty),
    .fifo_rdata (fifo_rdata),
    .fifo_r_en  (fifo_r_en),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last),
    .beats_out  (beats_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural FIFO with registered data_out; shares the adapter's reset.
  assign fifo_empty = (wr_ptr == rd_ptr);
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr     <= wr_ptr;
      fifo_rdata <= '0;
    end else if (fifo_r_en) begin
      fifo_rdata <= mem[rd_ptr];
      rd_ptr     <= rd_ptr + 1;
    end
  end

  always @(negedge clk) begin
    if (rst_n && m_valid && m_ready) begin
      got[n_got]      = m_data;
      got_last[n_got] = m_last;
      got_cyc[n_got]  = cyc;
      n_got           = n_got + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input fifo_word_t v);
    mem[wr_ptr] = v;
    wr_ptr      = wr_ptr + 1;
  endtask

  task automatic wait_got(input int target, input int budget);
    int k;
    k = 0;
    while (n_got < target && k < budget) begin
      step();
      k++;
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    en      = 1'b0;
    flush   = 1'b0;
    m_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_m_valid", 32'(m_valid), 0);
    chk("rst_m_data", 32'(m_data), 0);
    chk("rst_m_last", 32'(m_last), 0);
    chk("rst_fifo_r_en", 32'(fifo_r_en), 0);
    chk("rst_beats_out", 32'(beats_out), 0);
    step();
    rst_n = 1'b1;

    // Single word
    push_word(8'hA5);
    en      = 1'b1;
    m_ready = 1'b1;
    @(negedge clk);
    chk("single_r_en", 32'(fifo_r_en), 1);
    chk("single_no_early_valid", 32'(m_valid), 0);
    wait_got(1, 5);
    chk("single_count", 32'(n_got), 1);
    chk("single_data", 32'(got[0]), 32'hA5);
    chk("single_last", 32'(got_last[0]), 0);
    @(negedge clk);
    chk("single_beats", 32'(beats_out), 1);

    // Flush an empty buffer to restart burst framing, then stream 8 words
    step();
    en    = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    for (int i = 1; i <= 8; i++) push_word(fifo_word_t'(i));
    en = 1'b1;
    wait_got(9, 20);
    chk("stream_count", 32'(n_got), 9);
    for (int i = 0; i < 8; i++) begin
      chk("stream_data", 32'(got[1+i]), 32'(i + 1));
      chk("stream_last", 32'(got_last[1+i]), (i == 3 || i == 7) ? 1 : 0);
    end
    for (int i = 1; i < 8; i++) chk("stream_no_bubble", 32'(got_cyc[1+i] - got_cyc[i]), 1);

    // Backpressure: buffer fills to two and reads stop
    m_ready = 1'b0;
    rd_base = rd_ptr;
    for (int i = 0; i < 6; i++) push_word(8'h10 + fifo_word_t'(i));
    repeat (5) step();
    @(negedge clk);
    chk("bp_valid", 32'(m_valid), 1);
    chk("bp_head", 32'(m_data), 32'h10);
    chk("bp_r_en_low", 32'(fifo_r_en), 0);
    chk("bp_reads_issued", 32'(rd_ptr - rd_base), 2);
    chk("bp_beats", 32'(beats_out), 9);
    step();
    m_ready = 1'b1;
    wait_got(15, 20);
    chk("bp_count", 32'(n_got), 15);
    for (int i = 0; i < 6; i++) chk("bp_data", 32'(got[9+i]), 32'h10 + 32'(i));
    chk("bp_last_beat4", 32'(got_last[12]), 1);
    chk("bp_last_beat6", 32'(got_last[14]), 0);

    // Flush with a word in flight; burst count sits at 2 going in
    m_ready = 1'b0;
    en      = 1'b0;
    rd_base = rd_ptr;
    for (int i = 0; i < 4; i++) push_word(8'h30 + fifo_word_t'(i));
    en = 1'b1;
    @(negedge clk);
    chk("flush_pre_r_en", 32'(fifo_r_en), 1);
    step();
    flush = 1'b1;
    @(negedge clk);
    chk("flush_r_en_blocked", 32'(fifo_r_en), 0);
    step();
    flush = 1'b0;
    en    = 1'b0;
    @(negedge clk);
    chk("flush_valid_low", 32'(m_valid), 0);
    chk("flush_reads_issued", 32'(rd_ptr - rd_base), 1);
    step();
    m_ready = 1'b1;
    en      = 1'b1;
    wait_got(18, 20);
    chk("flush_count", 32'(n_got), 18);
    for (int i = 0; i < 3; i++) begin
      chk("flush_data", 32'(got[15+i]), 32'h31 + 32'(i));
      chk("flush_last_restart", 32'(got_last[15+i]), 0);
    end
    @(negedge clk);
    chk("flush_beats_kept", 32'(beats_out), 18);

    // en toggled every two cycles; burst count sits at 3 going in
    step();
    for (int i = 0; i < 8; i++) push_word(8'h20 + fifo_word_t'(i));
    for (int k = 0; k < 40 && n_got < 26; k++) begin
      en = ((k / 2) % 2 == 0);
      @(negedge clk);
      if (!en) chk("toggle_no_read", 32'(fifo_r_en), 0);
      step();
    end
    en = 1'b1;
    chk("toggle_count", 32'(n_got), 26);
    for (int i = 0; i < 8; i++) chk("toggle_data", 32'(got[18+i]), 32'h20 + 32'(i));
    chk("toggle_last_0", 32'(got_last[18]), 1);
    chk("toggle_last_1", 32'(got_last[19]), 0);
    chk("toggle_last_4", 32'(got_last[22]), 1);
    @(negedge clk);
    chk("toggle_beats", 32'(beats_out), 26);

    // Asynchronous reset with two words held and m_last showing
    step();
    m_ready = 1'b0;
    push_word(8'h40);
    push_word(8'h41);
    push_word(8'h42);
    repeat (4) step();
    @(negedge clk);
    chk("pre_rst_valid", 32'(m_valid), 1);
    chk("pre_rst_data", 32'(m_data), 32'h40);
    chk("pre_rst_last", 32'(m_last), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_m_valid", 32'(m_valid), 0);
    chk("arst_m_data", 32'(m_data), 0);
    chk("arst_m_last", 32'(m_last), 0);
    chk("arst_fifo_r_en", 32'(fifo_r_en), 0);
    chk("arst_beats_out", 32'(beats_out), 0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) push_word(8'h50 + fifo_word_t'(i));
    m_ready = 1'b1;
    wait_got(30, 20);
    chk("post_rst_count", 32'(n_got), 30);
    for (int i = 0; i < 4; i++) begin
      chk("post_rst_data", 32'(got[26+i]), 32'h50 + 32'(i));
      chk("post_rst_last", 32'(got_last[26+i]), (i == 3) ? 1 : 0);
    end
    @(negedge clk);
    chk("post_rst_beats", 32'(beats_out), 4);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
